// File: rtl/flex_counter_ext.sv
// Up/down counter with programmable reload point, wrap/saturate mode and a prescaler.
// Produces a combinational terminal flag and a registered one-cycle wrap pulse.
module flex_counter_ext #(
  parameter int NUM_CNT_BITS = 4,
  parameter int PRE_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_down,
  input  logic                    saturate,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_CNT_BITS-1:0] reload_val,
  input  logic [PRE_BITS-1:0]     prescale_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    rollover_pulse
);

  logic [PRE_BITS-1:0]     pre_cnt;
  logic [PRE_BITS-1:0]     pre_cnt_nxt;
  logic [NUM_CNT_BITS-1:0] count_nxt;
  logic [NUM_CNT_BITS-1:0] terminal;
  logic                    at_term;
  logic                    step;
  logic                    pulse_nxt;

  // The terminal follows count_down immediately; the prescaler is unaffected by direction.
  assign terminal      = count_down ? reload_val : rollover_val;
  assign at_term       = (count_out == terminal);
  assign step          = count_enable && (pre_cnt == prescale_val);
  assign rollover_flag = at_term;

  always_comb begin
    count_nxt   = count_out;
    pre_cnt_nxt = pre_cnt;
    pulse_nxt   = 1'b0;
    if (clear) begin
      count_nxt   = '0;
      pre_cnt_nxt = '0;
    end else if (load) begin
      count_nxt   = load_val;
      pre_cnt_nxt = '0;
    end else if (count_enable) begin
      // pre_cnt above prescale_val simply free-runs through 2^PRE_BITS-1 back to 0.
      pre_cnt_nxt = step ? '0 : pre_cnt + 1'b1;
      if (step) begin
        if (at_term) begin
          if (!saturate) begin
            count_nxt = count_down ? rollover_val : reload_val;
            pulse_nxt = 1'b1;
          end
        end else begin
          count_nxt = count_down ? count_out - 1'b1 : count_out + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_out      <= '0;
      pre_cnt        <= '0;
      rollover_pulse <= 1'b0;
    end else begin
      count_out      <= count_nxt;
      pre_cnt        <= pre_cnt_nxt;
      rollover_pulse <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_flex_counter_ext.sv
// Directed bench for flex_counter_ext: the driver pushes hand-computed {count, flag, pulse}
// per clock edge, a negedge monitor pops and compares.
module tb_flex_counter_ext;

  localparam int W = 4;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         count_enable;
  logic         count_down;
  logic         saturate;
  logic [W-1:0] rollover_val;
  logic [W-1:0] reload_val;
  logic [P-1:0] prescale_val;
  logic [W-1:0] count_out;
  logic         rollover_flag;
  logic         rollover_pulse;

  logic [W+1:0] exp_q[$];
  string        name_q[$];
  int           tests = 0;
  int           fails = 0;

  flex_counter_ext #(.NUM_CNT_BITS(W), .PRE_BITS(P)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_down(count_down), .saturate(saturate),
    .rollover_val(rollover_val), .reload_val(reload_val), .prescale_val(prescale_val),
    .count_out(count_out), .rollover_flag(rollover_flag), .rollover_pulse(rollover_pulse)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: inputs are held across one posedge, then the expected post-edge state is queued.
  task automatic tick(input string nm, input logic [W-1:0] ec, input logic ef, input logic ep);
    @(posedge clk);
    exp_q.push_back({ec, ef, ep});
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W+1:0] exp_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      tests++;
      if ({count_out, rollover_flag, rollover_pulse} !== exp_v) begin
        fails++;
        $display("FAIL %s: got count=%0d flag=%0b pulse=%0b, expected count=%0d flag=%0b pulse=%0b",
                 nm, count_out, rollover_flag, rollover_pulse,
                 exp_v[W+1:2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0; count_enable = 1'b1;
    count_down = 1'b0; saturate = 1'b0; rollover_val = 4'd0; reload_val = 4'd0;
    prescale_val = '0;
    @(negedge clk); #1;

    // 1: reset with enable active
    tick("reset0", 4'd0, 1'b1, 1'b0);
    rollover_val = 4'd7;
    tick("reset1", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // 2: up counting with wrap 5 -> 1
    rollover_val = 4'd5; reload_val = 4'd1;
    tick("up_1", 4'd1, 1'b0, 1'b0);
    tick("up_2", 4'd2, 1'b0, 1'b0);
    tick("up_3", 4'd3, 1'b0, 1'b0);
    tick("up_4", 4'd4, 1'b0, 1'b0);
    tick("up_5", 4'd5, 1'b1, 1'b0);
    tick("up_wrap1", 4'd1, 1'b0, 1'b1);
    tick("up_2b", 4'd2, 1'b0, 1'b0);
    tick("up_3b", 4'd3, 1'b0, 1'b0);
    tick("up_4b", 4'd4, 1'b0, 1'b0);
    tick("up_5b", 4'd5, 1'b1, 1'b0);
    tick("up_wrap2", 4'd1, 1'b0, 1'b1);
    tick("up_2c", 4'd2, 1'b0, 1'b0);
    count_enable = 1'b0;
    tick("up_hold", 4'd2, 1'b0, 1'b0);

    // 3: load then count down with wrap 0 -> 9
    load = 1'b1; load_val = 4'd3; count_down = 1'b1;
    reload_val = 4'd0; rollover_val = 4'd9;
    tick("dn_load", 4'd3, 1'b0, 1'b0);
    load = 1'b0; count_enable = 1'b1;
    tick("dn_2", 4'd2, 1'b0, 1'b0);
    tick("dn_1", 4'd1, 1'b0, 1'b0);
    tick("dn_0", 4'd0, 1'b1, 1'b0);
    tick("dn_wrap9", 4'd9, 1'b0, 1'b1);
    tick("dn_8", 4'd8, 1'b0, 1'b0);

    // 4: saturate at rollover_val
    count_enable = 1'b0; count_down = 1'b0; saturate = 1'b1; rollover_val = 4'd3;
    clear = 1'b1;
    tick("sat_clear", 4'd0, 1'b0, 1'b0);
    clear = 1'b0; count_enable = 1'b1;
    tick("sat_1", 4'd1, 1'b0, 1'b0);
    tick("sat_2", 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick("sat_hold", 4'd3, 1'b1, 1'b0);

    // 5: prescale by 3, with enable gaps mid-phase
    saturate = 1'b0; rollover_val = 4'd9; prescale_val = 4'd2; count_enable = 1'b0;
    clear = 1'b1;
    tick("pre_clear", 4'd0, 1'b0, 1'b0);
    clear = 1'b0; count_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [W-1:0] ev;
      ev = W'((i + 1) / 3);
      tick("pre_run", ev, 1'b0, 1'b0);
    end
    tick("pre_phase1", 4'd3, 1'b0, 1'b0);
    count_enable = 1'b0;
    for (int i = 0; i < 3; i++) tick("pre_gap", 4'd3, 1'b0, 1'b0);
    count_enable = 1'b1;
    tick("pre_resume", 4'd3, 1'b0, 1'b0);
    tick("pre_step", 4'd4, 1'b0, 1'b0);

    // 6: priorities
    rst = 1'b1; load = 1'b1; load_val = 4'd6;
    tick("rst_over_load", 4'd0, 1'b0, 1'b0);
    rst = 1'b0; clear = 1'b1;
    tick("clear_over_load", 4'd0, 1'b0, 1'b0);
    clear = 1'b0;
    tick("load_over_enable", 4'd6, 1'b0, 1'b0);
    load = 1'b0;
    tick("mid_prescale", 4'd6, 1'b0, 1'b0);
    clear = 1'b1;
    tick("clear_mid_prescale", 4'd0, 1'b0, 1'b0);
    clear = 1'b0;
    tick("post_clear_a", 4'd0, 1'b0, 1'b0);
    tick("post_clear_b", 4'd0, 1'b0, 1'b0);
    tick("post_clear_step", 4'd1, 1'b0, 1'b0);

    // Drain: every queued expectation must have been consumed.
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
